// File: rtl/sram_1p_bm_march_if.sv
// sram_1p_bm_march_if: functional port and BIST status bundle of the SRAM macro.
// SRAM_BIST_FAULT_INJ_EN adds the stuck-at-1 fault-injection controls.
interface sram_1p_bm_march_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
);
  logic              A_MEN, A_WEN, A_REN;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DIN, A_BM, A_DOUT;
  logic              A_BIST_START, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL;
  logic [ADDR_W-1:0] A_BIST_FAIL_ADDR;
  logic [ERR_W-1:0]  A_BIST_ERR_CNT;
`ifdef SRAM_BIST_FAULT_INJ_EN
  logic                      A_FI_EN;
  logic [ADDR_W-1:0]         A_FI_ADDR;
  logic [$clog2(DATA_W)-1:0] A_FI_BIT;
`endif
  modport master (
`ifdef SRAM_BIST_FAULT_INJ_EN
    output A_FI_EN, A_FI_ADDR, A_FI_BIT,
`endif
    output A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM, A_BIST_START,
    input  A_DOUT, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_ERR_CNT
  );
  modport slave (
`ifdef SRAM_BIST_FAULT_INJ_EN
    input  A_FI_EN, A_FI_ADDR, A_FI_BIT,
`endif
    input  A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM, A_BIST_START,
    output A_DOUT, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_ERR_CNT
  );
endinterface

// File: rtl/sram_1p_bm_march.sv
// sram_1p_bm_march: single-port bit-masked SRAM with an integrated March C- self-test engine.
// SRAM_BIST_FAULT_INJ_EN adds a stuck-at-1 read fault on one selectable bit of one word.
module sram_1p_bm_march #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int ERR_W  = 8
) (
  input logic A_CLK,
  input logic A_RST_N,
  sram_1p_bm_march_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, a, chk_addr, fail_addr;
  logic ph, ph_n, idle, busy, single, up, last, adv, elem_end;
  logic b_we, b_re, b_bit, in_rng, we, re, chk_v, chk_exp, miscmp, fail;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] m, d, raw, wr_word, fi, dout;
  logic [ERR_W-1:0] err_cnt;
  assign idle = state == IDLE || state == DONE;
  assign busy = !idle;
  assign single = state == M0 || state == M5;
  assign up = !(state == M3 || state == M4);
  assign last = up ? cnt == LAST : cnt == '0;
  assign adv = single || ph;
  assign elem_end = adv && last;
  // ph selects the read (0) or write (1) half of a two-op element
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ph_n = ph;
    b_re = 1'b0;
    b_we = 1'b0;
    b_bit = 1'b0;
    if (idle) begin
      if (bus.A_BIST_START) begin
        state_n = M0;
        cnt_n = '0;
        ph_n = 1'b0;
      end
    end else if (state == DRAIN) begin
      state_n = DONE;
    end else begin
      b_re = state != M0 && !ph;
      b_we = !b_re;
      b_bit = b_re ? (state == M2 || state == M4) : (state == M1 || state == M3);
      if (elem_end) begin
        state_n = state_t'(state + 4'd1);
        cnt_n = (state == M2 || state == M3) ? LAST : '0;
        ph_n = 1'b0;
      end else begin
        ph_n = !single && !ph;
        cnt_n = adv ? (up ? cnt + 1'b1 : cnt - 1'b1) : cnt;
      end
    end
  end
  assign in_rng = {1'b0, bus.A_ADDR} < DEPTH_C;
  assign a = busy ? cnt : bus.A_ADDR;
  assign we = busy ? b_we : bus.A_MEN && bus.A_WEN && in_rng;
  assign re = busy ? b_re : bus.A_MEN && bus.A_REN && in_rng;
  assign m = busy ? '1 : bus.A_BM;
  assign d = busy ? {DATA_W{b_bit}} : bus.A_DIN;
  assign raw = mem[a[IW-1:0]];
  assign wr_word = (raw & ~m) | (d & m);
`ifdef SRAM_BIST_FAULT_INJ_EN
  assign fi = bus.A_FI_EN && bus.A_FI_ADDR == a ? DATA_W'(1) << bus.A_FI_BIT : '0;
`else
  assign fi = '0;
`endif
  assign miscmp = chk_v && dout != {DATA_W{chk_exp}};
  always_ff @(posedge A_CLK) begin
    if (we) mem[a[IW-1:0]] <= wr_word;
  end
  always_ff @(posedge A_CLK) begin
    if (!A_RST_N) begin
      state <= IDLE;
      cnt <= '0;
      ph <= 1'b0;
      dout <= '0;
      chk_v <= 1'b0;
      chk_exp <= 1'b0;
      chk_addr <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ph <= ph_n;
      if (re) dout <= (we ? wr_word : raw) | fi;
      chk_v <= b_re;
      chk_exp <= b_bit;
      chk_addr <= cnt;
      if (idle && bus.A_BIST_START) begin
        fail <= 1'b0;
        fail_addr <= '0;
        err_cnt <= '0;
      end else if (miscmp) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= chk_addr;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
  assign bus.A_DOUT = dout;
  assign bus.A_BIST_BUSY = busy;
  assign bus.A_BIST_DONE = state == DONE;
  assign bus.A_BIST_FAIL = fail;
  assign bus.A_BIST_FAIL_ADDR = fail_addr;
  assign bus.A_BIST_ERR_CNT = err_cnt;
endmodule

// File: tb/tb_sram_1p_bm_march.sv
// tb_sram_1p_bm_march: functional port vectors, random traffic against an array model, and BIST march scenarios.
module tb_sram_1p_bm_march;
  localparam int DW = 48;
  localparam int AW = 8;
  localparam int DM = 4;
  logic A_CLK = 1'b0;
  logic A_RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 A_CLK = ~A_CLK;
  sram_1p_bm_march_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(8)) fa ();
  sram_1p_bm_march_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(8)) mb ();
  sram_1p_bm_march #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .ERR_W(8))
    u_fa (.A_CLK(A_CLK), .A_RST_N(A_RST_N), .bus(fa));
  sram_1p_bm_march #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DM), .ERR_W(8))
    u_mb (.A_CLK(A_CLK), .A_RST_N(A_RST_N), .bus(mb));
`ifdef SRAM_BIST_FAULT_INJ_EN
  sram_1p_bm_march_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(2)) m2 ();
  sram_1p_bm_march_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(1)) m1 ();
  sram_1p_bm_march #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DM), .ERR_W(2))
    u_m2 (.A_CLK(A_CLK), .A_RST_N(A_RST_N), .bus(m2));
  sram_1p_bm_march #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DM), .ERR_W(1))
    u_m1 (.A_CLK(A_CLK), .A_RST_N(A_RST_N), .bus(m1));
  assign m2.A_MEN = mb.A_MEN;  assign m1.A_MEN = mb.A_MEN;
  assign m2.A_WEN = mb.A_WEN;  assign m1.A_WEN = mb.A_WEN;
  assign m2.A_REN = mb.A_REN;  assign m1.A_REN = mb.A_REN;
  assign m2.A_ADDR = mb.A_ADDR;  assign m1.A_ADDR = mb.A_ADDR;
  assign m2.A_DIN = mb.A_DIN;  assign m1.A_DIN = mb.A_DIN;
  assign m2.A_BM = mb.A_BM;  assign m1.A_BM = mb.A_BM;
  assign m2.A_BIST_START = mb.A_BIST_START;  assign m1.A_BIST_START = mb.A_BIST_START;
  assign m2.A_FI_EN = mb.A_FI_EN;  assign m1.A_FI_EN = mb.A_FI_EN;
  assign m2.A_FI_ADDR = mb.A_FI_ADDR;  assign m1.A_FI_ADDR = mb.A_FI_ADDR;
  assign m2.A_FI_BIT = mb.A_FI_BIT;  assign m1.A_FI_BIT = mb.A_FI_BIT;
`endif

  typedef struct {
    logic men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm, exp;
  } vec_t;
  vec_t tbl[9];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] ref_dout;

  task automatic step();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fdrive(input logic men, wen, ren, input logic [AW-1:0] addr, input logic [DW-1:0] din, bm);
    fa.A_MEN = men; fa.A_WEN = wen; fa.A_REN = ren;
    fa.A_ADDR = addr; fa.A_DIN = din; fa.A_BM = bm;
  endtask

  task automatic mdrive(input logic men, wen, ren, input logic [AW-1:0] addr, input logic [DW-1:0] din, bm);
    mb.A_MEN = men; mb.A_WEN = wen; mb.A_REN = ren;
    mb.A_ADDR = addr; mb.A_DIN = din; mb.A_BM = bm;
  endtask

  // Pulses start and counts busy cycles; poke drives starts and functional traffic while busy
  task automatic march(input bit poke, input int rst_at, output int n);
    mb.A_BIST_START = 1'b1;
    step();
    mb.A_BIST_START = 1'b0;
    chk("done_clear_on_start", mb.A_BIST_DONE, 0);
    n = 0;
    while (mb.A_BIST_BUSY && n < 1000) begin
      n++;
      if (n == rst_at) begin
        A_RST_N = 1'b0;
        step();
        A_RST_N = 1'b1;
        return;
      end
      if (poke) begin
        mb.A_BIST_START = (n % 3) == 0;
        mdrive(1'b1, n == 20, 1'b1, '0, '1, '1);
      end
      step();
    end
    mb.A_BIST_START = 1'b0;
    mdrive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int n;
    fdrive(0, 0, 0, '0, '0, '0);
    mdrive(0, 0, 0, '0, '0, '0);
    fa.A_BIST_START = 1'b0;
    mb.A_BIST_START = 1'b0;
`ifdef SRAM_BIST_FAULT_INJ_EN
    fa.A_FI_EN = 1'b0; fa.A_FI_ADDR = '0; fa.A_FI_BIT = '0;
    mb.A_FI_EN = 1'b0; mb.A_FI_ADDR = '0; mb.A_FI_BIT = '0;
`endif
    repeat (2) step();
    chk("rst_dout", fa.A_DOUT, 0);
    chk("rst_busy", mb.A_BIST_BUSY, 0);
    chk("rst_done", mb.A_BIST_DONE, 0);
    chk("rst_fail", mb.A_BIST_FAIL, 0);
    chk("rst_fail_addr", mb.A_BIST_FAIL_ADDR, 0);
    chk("rst_err_cnt", mb.A_BIST_ERR_CNT, 0);
    A_RST_N = 1'b1;
    step();

    tbl[0] = '{1, 1, 0, 8'd5, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0};
    tbl[1] = '{1, 1, 0, 8'd5, 48'h0, 48'h0000_0000_00FF, 48'h0};
    tbl[2] = '{1, 0, 1, 8'd5, 48'h0, 48'h0, 48'hFFFF_FFFF_FF00};
    tbl[3] = '{0, 1, 1, 8'd5, 48'h0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FF00};
    tbl[4] = '{1, 0, 1, 8'd5, 48'h0, 48'h0, 48'hFFFF_FFFF_FF00};
    tbl[5] = '{1, 1, 1, 8'd9, 48'h1234_5678_9ABC, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC};
    tbl[6] = '{1, 1, 1, 8'd9, 48'h0, 48'h0000_0000_FF00, 48'h1234_5678_00BC};
    tbl[7] = '{1, 0, 0, 8'd9, 48'h0, 48'h0, 48'h1234_5678_00BC};
    tbl[8] = '{1, 0, 1, 8'd5, 48'h0, 48'h0, 48'hFFFF_FFFF_FF00};
    for (int i = 0; i < 9; i++) begin
      fdrive(tbl[i].men, tbl[i].wen, tbl[i].ren, tbl[i].addr, tbl[i].din, tbl[i].bm);
      step();
      chk($sformatf("vec%0d_dout", i), fa.A_DOUT, tbl[i].exp);
    end

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = DW'({$urandom(), $urandom()});
      fdrive(1, 1, 0, AW'(i), ref_mem[i], '1);
      step();
    end
    ref_dout = fa.A_DOUT;
    for (int i = 0; i < 300; i++) begin
      logic men, wen, ren;
      logic [3:0] ad;
      logic [DW-1:0] din, bm;
      men = $urandom_range(0, 3) != 0;
      wen = $urandom_range(0, 1) == 1;
      ren = $urandom_range(0, 1) == 1;
      ad = 4'($urandom_range(0, 15));
      din = DW'({$urandom(), $urandom()});
      bm = DW'({$urandom(), $urandom()});
      fdrive(men, wen, ren, {4'h0, ad}, din, bm);
      if (men && wen) ref_mem[ad] = (ref_mem[ad] & ~bm) | (din & bm);
      if (men && ren) ref_dout = ref_mem[ad];
      step();
      chk($sformatf("rand%0d_dout", i), fa.A_DOUT, ref_dout);
    end
    fdrive(0, 0, 0, '0, '0, '0);

    march(0, 0, n);
    chk("clean_busy_cycles", n, 10 * DM + 1);
    chk("clean_done", mb.A_BIST_DONE, 1);
    chk("clean_fail", mb.A_BIST_FAIL, 0);
    chk("clean_err_cnt", mb.A_BIST_ERR_CNT, 0);
    chk("clean_fail_addr", mb.A_BIST_FAIL_ADDR, 0);
    repeat (3) step();
    chk("done_held", mb.A_BIST_DONE, 1);
    for (int i = 0; i < DM; i++) begin
      mdrive(1, 0, 1, AW'(i), '0, '0);
      step();
      chk($sformatf("post_march_word%0d", i), mb.A_DOUT, 0);
    end

    march(1, 0, n);
    chk("poke_busy_cycles", n, 10 * DM + 1);
    chk("poke_done", mb.A_BIST_DONE, 1);
    chk("poke_fail", mb.A_BIST_FAIL, 0);

    mdrive(1, 1, 1, 8'd1, 48'hABC, '1);
    step();
    chk("small_wr_rd", mb.A_DOUT, 48'hABC);
    mdrive(1, 1, 1, 8'd5, '1, '1);
    step();
    chk("oor_dout_hold", mb.A_DOUT, 48'hABC);
    mdrive(1, 0, 1, 8'd1, '0, '0);
    step();
    chk("oor_no_alias", mb.A_DOUT, 48'hABC);
    mdrive(0, 0, 0, '0, '0, '0);

    march(0, 17, n);
    chk("midrst_busy", mb.A_BIST_BUSY, 0);
    chk("midrst_done", mb.A_BIST_DONE, 0);
    chk("midrst_fail", mb.A_BIST_FAIL, 0);
    chk("midrst_err_cnt", mb.A_BIST_ERR_CNT, 0);
    march(0, 0, n);
    chk("rerun_busy_cycles", n, 10 * DM + 1);
    chk("rerun_done", mb.A_BIST_DONE, 1);
    chk("rerun_fail", mb.A_BIST_FAIL, 0);

`ifdef SRAM_BIST_FAULT_INJ_EN
    mb.A_FI_EN = 1'b1; mb.A_FI_ADDR = 8'd2; mb.A_FI_BIT = 6'd7;
    march(0, 0, n);
    chk("fi_busy_cycles", n, 10 * DM + 1);
    chk("fi_fail", mb.A_BIST_FAIL, 1);
    chk("fi_fail_addr", mb.A_BIST_FAIL_ADDR, 2);
    chk("fi_err_cnt", mb.A_BIST_ERR_CNT, 3);
    chk("fi_err_cnt_w2", m2.A_BIST_ERR_CNT, 3);
    chk("fi_err_cnt_w1", m1.A_BIST_ERR_CNT, 1);
    chk("fi_fail_w1", m1.A_BIST_FAIL, 1);
    mdrive(1, 0, 1, 8'd2, '0, '0);
    step();
    chk("fi_func_read", mb.A_DOUT, 48'h80);
    mdrive(0, 0, 0, '0, '0, '0);
    mb.A_FI_EN = 1'b0;
    march(0, 0, n);
    chk("fi_off_fail", mb.A_BIST_FAIL, 0);
    chk("fi_off_err_cnt", mb.A_BIST_ERR_CNT, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
